// File: rtl/backlight_pkg.sv
// Shared state type and default timing constants for the backlight controller.
package backlight_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_FADE = 2'd2
    } bl_state_t;

    localparam int DEF_CLK_PER_SEC = 50000;
    localparam int DEF_TIMEOUT_SEC = 3;
    localparam int DEF_FADE_DIV    = 64;

endpackage

// File: rtl/backlight_pwm.sv
// Free-running PWM counter and registered duty compare driving the backlight.
module backlight_pwm
    import backlight_pkg::*;
#(
    parameter int PWM_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PWM_WIDTH:0] duty,
    output logic               light
);

    logic [PWM_WIDTH-1:0] pwm_cnt_reg;
    logic                 light_reg;

    // Duty is one bit wider than the counter so a full-scale duty keeps light high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_reg <= '0;
            light_reg   <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            light_reg   <= enable && ({1'b0, pwm_cnt_reg} < duty);
        end
    end

    assign light = light_reg;

endmodule

// File: rtl/backlight_pwm_controller.sv
// Backlight controller: wake/timeout FSM, brightness levels and PWM drive.
// Optional fade-out on timeout is built when BACKLIGHT_FADE_EN is defined.
module backlight_pwm_controller
    import backlight_pkg::*;
#(
    parameter int CLK_PER_SEC = DEF_CLK_PER_SEC,
    parameter int TIMEOUT_SEC = DEF_TIMEOUT_SEC,
    parameter int PWM_WIDTH   = 4,
    parameter int NUM_LEVELS  = 4,
    parameter int FADE_DIV    = DEF_FADE_DIV
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_backlight,
    input  logic                          btn_level,
    output logic                          light,
    output logic                          active,
    output logic [$clog2(NUM_LEVELS)-1:0] level
);

    localparam int TIMER_MAX = TIMEOUT_SEC * CLK_PER_SEC - 1;
    localparam int TW        = (TIMER_MAX > 0) ? $clog2(TIMER_MAX + 1) : 1;
    localparam int LW        = $clog2(NUM_LEVELS);

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_MAX);
    localparam logic [LW-1:0] LEVEL_TOP  = LW'(NUM_LEVELS - 1);

    generate
        if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 255 || NUM_LEVELS < 2 ||
            NUM_LEVELS > (1 << PWM_WIDTH) || FADE_DIV < 1) begin : g_param_check
            $error("backlight_pwm_controller: parameter out of range");
        end
    endgenerate

    function automatic logic [PWM_WIDTH:0] level_duty(input logic [LW-1:0] k);
        logic [31:0] num;
        num = (32'(k) + 32'd1) << PWM_WIDTH;
        return (PWM_WIDTH + 1)'(num / 32'(NUM_LEVELS));
    endfunction

    bl_state_t          state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [LW-1:0]      level_reg, level_next, level_inc;
    logic [PWM_WIDTH:0] duty_reg, duty_next;
    logic [1:0]         btn_in, btn_q_reg, press;
    logic               arm_reg;
    logic               bl_press, lv_press;

`ifdef BACKLIGHT_FADE_EN
    localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
    logic [DW-1:0] div_reg, div_next;
`endif

    // arm_reg masks the first cycle after reset so a button held through reset is not a press.
    assign btn_in = {btn_level, btn_backlight};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            assign press[gi] = btn_in[gi] & ~btn_q_reg[gi] & arm_reg;
        end
    endgenerate

    assign bl_press  = press[0];
    assign lv_press  = press[1];
    assign level_inc = (level_reg == LEVEL_TOP) ? '0 : level_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_OFF;
            timer_reg <= '0;
            level_reg <= LEVEL_TOP;
            duty_reg  <= level_duty(LEVEL_TOP);
            btn_q_reg <= '0;
            arm_reg   <= 1'b0;
`ifdef BACKLIGHT_FADE_EN
            div_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            level_reg <= level_next;
            duty_reg  <= duty_next;
            btn_q_reg <= btn_in;
            arm_reg   <= 1'b1;
`ifdef BACKLIGHT_FADE_EN
            div_reg   <= div_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = (timer_reg != '0) ? timer_reg - 1'b1 : '0;
        level_next = level_reg;
        duty_next  = duty_reg;
`ifdef BACKLIGHT_FADE_EN
        div_next   = div_reg;
`endif
        case (state_reg)
            ST_OFF: begin
                if (bl_press) begin
                    state_next = ST_ON;
                    timer_next = TIMER_LOAD;
                    duty_next  = level_duty(level_reg);
                end
            end
            ST_ON: begin
                if (bl_press || lv_press) begin
                    timer_next = TIMER_LOAD;
                end
                if (lv_press) begin
                    level_next = level_inc;
                    duty_next  = level_duty(level_inc);
                end else if (!bl_press && timer_reg == '0) begin
`ifdef BACKLIGHT_FADE_EN
                    state_next = ST_FADE;
                    div_next   = '0;
`else
                    state_next = ST_OFF;
`endif
                end
            end
`ifdef BACKLIGHT_FADE_EN
            ST_FADE: begin
                if (bl_press) begin
                    state_next = ST_ON;
                    timer_next = TIMER_LOAD;
                    duty_next  = level_duty(level_reg);
                    div_next   = '0;
                end else if (div_reg == DIV_LAST) begin
                    div_next = '0;
                    // Leave FADE on the same step that takes duty to zero.
                    if (duty_reg[PWM_WIDTH:1] == '0) begin
                        duty_next  = '0;
                        state_next = ST_OFF;
                    end else begin
                        duty_next = duty_reg - 1'b1;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
`endif
            default: state_next = ST_OFF;
        endcase
    end

    backlight_pwm #(
        .PWM_WIDTH(PWM_WIDTH)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .enable(state_reg != ST_OFF),
        .duty  (duty_reg),
        .light (light)
    );

    assign active = (state_reg != ST_OFF);
    assign level  = level_reg;

endmodule

// File: tb/tb_backlight_pwm_controller.sv
// Self-checking bench: timestamp-based reference model plus directed and random stimulus.
module tb_backlight_pwm_controller;

    localparam int CPS    = 10;
    localparam int TOS    = 3;
    localparam int PW     = 4;
    localparam int NL     = 4;
    localparam int FD     = 2;
    localparam int PERIOD = 1 << PW;
    localparam int T_ON   = CPS * TOS;
`ifdef BACKLIGHT_FADE_EN
    localparam int FADE_TOP = PERIOD * FD;
`else
    localparam int FADE_TOP = 0;
`endif

    logic       clk;
    logic       reset;
    logic       btn_backlight;
    logic       btn_level;
    logic       light;
    logic       active;
    logic [1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    backlight_pwm_controller #(
        .CLK_PER_SEC(CPS),
        .TIMEOUT_SEC(TOS),
        .PWM_WIDTH  (PW),
        .NUM_LEVELS (NL),
        .FADE_DIV   (FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_backlight(btn_backlight),
        .btn_level    (btn_level),
        .light        (light),
        .active       (active),
        .level        (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the light is lit from a wake edge until on_end, then (optionally)
    // fades from fade_start with duty derived from elapsed time.
    int cyc = 0;
    bit m_valid = 0;
    bit m_lit, m_first, m_prev_bl, m_prev_lv, m_light;
    int m_level, m_on_end, m_fade_start, m_since_rst;

    function automatic int ld(input int k);
        return ((k + 1) * PERIOD) / NL;
    endfunction

    function automatic int duty_after(input int e);
        int d;
        if (m_fade_start < 0) return ld(m_level);
        d = ld(m_level) - (e - m_fade_start) / FD;
        return (d < 0) ? 0 : d;
    endfunction

    always @(posedge clk) begin
        bit bl_p, lv_p;
        cyc++;
        if (!reset) begin
            m_valid      = 1;
            m_lit        = 0;
            m_light      = 0;
            m_level      = NL - 1;
            m_fade_start = -1;
            m_since_rst  = 0;
            m_first      = 1;
        end else begin
            m_light = m_lit && ((m_since_rst % PERIOD) < duty_after(cyc - 1));
            bl_p = btn_backlight && !m_prev_bl && !m_first;
            lv_p = btn_level && !m_prev_lv && !m_first;
            if (!m_lit) begin
                if (bl_p) begin
                    m_lit        = 1;
                    m_on_end     = cyc + T_ON;
                    m_fade_start = -1;
                end
            end else if (m_fade_start < 0) begin
                if (bl_p || lv_p) m_on_end = cyc + T_ON;
                if (lv_p) m_level = (m_level + 1) % NL;
                else if (!bl_p && cyc == m_on_end) begin
`ifdef BACKLIGHT_FADE_EN
                    m_fade_start = cyc;
`else
                    m_lit = 0;
`endif
                end
            end else begin
                if (bl_p) begin
                    m_fade_start = -1;
                    m_on_end     = cyc + T_ON;
                end else if (ld(m_level) - (cyc - m_fade_start) / FD <= 0) begin
                    m_lit        = 0;
                    m_fade_start = -1;
                end
            end
            m_since_rst++;
            m_first = 0;
        end
        m_prev_bl = btn_backlight;
        m_prev_lv = btn_level;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_light", int'(light), int'(m_light));
            chk("model_active", int'(active), int'(m_lit));
            chk("model_level", int'(level), m_level);
        end
    end

    task automatic pulse(input bit on_level);
        @(posedge clk);
        #1;
        if (on_level) btn_level = 1'b1;
        else btn_backlight = 1'b1;
        $display("tb: cycle %0d press %s", cyc, on_level ? "btn_level" : "btn_backlight");
        @(posedge clk);
        #1;
        btn_level     = 1'b0;
        btn_backlight = 1'b0;
    endtask

    task automatic count_active(output int n, output bit first_hi);
        bit done;
        n = 0;
        done = 0;
        first_hi = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (i == 0) first_hi = active;
            if (active) n++;
            else done = 1;
        end
        chk("active_drop_bound", int'(done), 1);
    endtask

    initial begin
        int n;
        int hi;
        bit f;
        reset = 1'b0;
        btn_backlight = 1'b0;
        btn_level = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_level", int'(level), 3);
        chk("reset_active", int'(active), 0);
        chk("reset_light", int'(light), 0);

        // Single wake: active next cycle, ON for 30 cycles (plus fade when built).
        pulse(0);
        count_active(n, f);
        chk("wake_active", int'(f), 1);
        chk("on_length", n, T_ON + FADE_TOP);
        $display("tb: wake lasted %0d cycles", n);

        // Retrigger 20 cycles into ON extends the phase to 30 after the retrigger.
        pulse(0);
        repeat (18) @(posedge clk);
        pulse(0);
        count_active(n, f);
        chk("retrigger_length", n, T_ON + FADE_TOP);
        $display("tb: after retrigger lasted %0d cycles", n);

        // Level wrap 3->0 gives duty 4: four high cycles per PWM period.
        pulse(0);
        pulse(1);
        @(negedge clk);
        chk("level_wrap", int'(level), 0);
        @(posedge clk);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (light) hi++;
        end
        chk("duty4_high_cycles", hi, 4);
        $display("tb: light high %0d of %0d cycles at level 0", hi, PERIOD);
        count_active(n, f);
        pulse(1);
        @(negedge clk);
        chk("level_in_off", int'(level), 0);
        chk("level_press_no_wake", int'(active), 0);

        // Press during fade restores ON; reset during fade blanks at once.
        pulse(0);
        repeat (33) @(posedge clk);
        pulse(0);
        @(negedge clk);
        chk("fade_press_active", int'(active), 1);
        repeat (33) @(posedge clk);
        #1 reset = 1'b0;
        $display("tb: cycle %0d reset asserted", cyc);
        @(posedge clk);
        @(negedge clk);
        chk("midrun_reset_light", int'(light), 0);
        chk("midrun_reset_active", int'(active), 0);

        // Button held across reset release must not wake.
        btn_backlight = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("held_through_reset", int'(active), 0);
        @(posedge clk);
        #1 btn_backlight = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 599) != 0);
            btn_backlight = ($urandom_range(0, 69) == 0);
            btn_level = ($urandom_range(0, 24) == 0);
            if (!reset || btn_backlight || btn_level)
                $display("tb: cycle %0d random reset_n=%0b bl=%0b lv=%0b",
                         cyc, reset, btn_backlight, btn_level);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        btn_backlight = 1'b0;
        btn_level = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
